// File: rtl/result_store_if.sv
// Handshake and status bundle for the result store: capture side, dump side and status.
interface result_store_if #(
  parameter int WIDTH = 20,
  parameter int AW    = 8
);
  logic             clear;
  logic             in_valid;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic             in_ready;
  logic             dump_start;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_x;
  logic [WIDTH-1:0] out_y;
  logic [AW-1:0]    out_idx;
  logic [AW-1:0]    count;
  logic             full;
  logic             dump_done;

  modport master (
    output clear, in_valid, in_x, in_y, dump_start, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_idx, count, full, dump_done
  );

  modport slave (
    input  clear, in_valid, in_x, in_y, dump_start, out_ready,
    output in_ready, out_valid, out_x, out_y, out_idx, count, full, dump_done
  );
endinterface

// File: rtl/result_store_dp.sv
// Result store: captures (x, y) pairs into an indexed buffer, then replays them
// in write order over a valid/ready stream with registered outputs.
module result_store_dp #(
   parameter int WIDTH = 20,
   parameter int DEPTH = 150,
   parameter int AW    = 8
) (
   input  logic           clk,
   input  logic           rst,
   result_store_if.slave  bus
);

   typedef enum logic [1:0] {S_CAPTURE, S_DUMP, S_DONE} state_t;

   localparam logic [AW-1:0] DEPTH_C = AW'(DEPTH);

   logic [2*WIDTH-1:0] store [DEPTH];

   state_t           state_q, state_d;
   logic [AW-1:0]    count_q, count_d;
   logic [AW-1:0]    out_idx_q, out_idx_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_x_q, out_x_d;
   logic [WIDTH-1:0] out_y_q, out_y_d;

   logic             wr_en;
   logic             rd_en;
   logic [AW-1:0]    rd_addr;
   logic [2*WIDTH-1:0] rd_word;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      out_idx_d   = out_idx_q;
      out_valid_d = out_valid_q;
      out_x_d     = out_x_q;
      out_y_d     = out_y_q;
      rd_en       = 1'b0;
      rd_addr     = '0;
      wr_en       = (state_q == S_CAPTURE) && bus.in_valid && (count_q < DEPTH_C) && !bus.clear;

      if (bus.clear) begin
         state_d     = S_CAPTURE;
         count_d     = '0;
         out_idx_d   = '0;
         out_valid_d = 1'b0;
      end else begin
         case (state_q)
            S_CAPTURE: begin
               if (wr_en) count_d = count_q + 1'b1;
               if (bus.dump_start) begin
                  if (count_d == '0) begin
                     state_d = S_DONE;
                  end else begin
                     state_d     = S_DUMP;
                     out_valid_d = 1'b1;
                     out_idx_d   = '0;
                     rd_en       = 1'b1;
                  end
               end
            end
            S_DUMP: begin
               if (out_valid_q && bus.out_ready) begin
                  if (out_idx_q == count_q - 1'b1) begin
                     state_d     = S_DONE;
                     out_valid_d = 1'b0;
                  end else begin
                     out_idx_d = out_idx_q + 1'b1;
                     rd_en     = 1'b1;
                     rd_addr   = out_idx_q + 1'b1;
                  end
               end
            end
            S_DONE: begin
               if (bus.dump_start && count_q != '0) begin
                  state_d     = S_DUMP;
                  out_valid_d = 1'b1;
                  out_idx_d   = '0;
                  rd_en       = 1'b1;
               end
            end
            default: state_d = S_CAPTURE;
         endcase
      end

      // A pair written on the same edge a dump starts must be forwarded into the first beat.
      rd_word = (wr_en && rd_addr == count_q) ? {bus.in_x, bus.in_y} : store[rd_addr];
      if (rd_en) {out_x_d, out_y_d} = rd_word;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_CAPTURE;
         count_q     <= '0;
         out_idx_q   <= '0;
         out_valid_q <= 1'b0;
         out_x_q     <= '0;
         out_y_q     <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         out_idx_q   <= out_idx_d;
         out_valid_q <= out_valid_d;
         out_x_q     <= out_x_d;
         out_y_q     <= out_y_d;
      end
   end

   // NOTE: the storage array has no reset; its contents are only read below count.
   always_ff @(posedge clk) begin
      if (wr_en) store[count_q] <= {bus.in_x, bus.in_y};
   end

   assign bus.in_ready  = (state_q == S_CAPTURE) && (count_q < DEPTH_C);
   assign bus.out_valid = out_valid_q;
   assign bus.out_x     = out_x_q;
   assign bus.out_y     = out_y_q;
   assign bus.out_idx   = out_idx_q;
   assign bus.count     = count_q;
   assign bus.full      = (count_q == DEPTH_C);
   assign bus.dump_done = (state_q == S_DONE);

endmodule

// File: tb/tb_result_store_dp.sv
// Self-checking bench for result_store_dp: a queue of written pairs is the reference,
// and every streamed beat is compared against it by index.
module tb_result_store_dp;

   localparam int WIDTH = 20;
   localparam int DEPTH = 150;
   localparam int AW    = 8;

   typedef struct packed {
      logic [WIDTH-1:0] x;
      logic [WIDTH-1:0] y;
   } pair_t;

   logic clk;
   logic rst;
   result_store_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

   result_store_dp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    num_checks = 0;
   int    num_errors = 0;
   pair_t model_q[$];
   bit    model_capture = 1'b1;
   bit    pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      num_checks++;
      if (obs !== exp) begin
         num_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      bus.clear = 1'b1;
      step();
      bus.clear = 1'b0;
      model_q.delete();
      model_capture = 1'b1;
   endtask

   // One write attempt; acceptance is decided from the model's view of the store.
   task automatic write_pair(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      bit acc;
      acc = model_capture && (model_q.size() < DEPTH);
      bus.in_valid = 1'b1;
      bus.in_x     = x;
      bus.in_y     = y;
      check("in_ready", 64'(bus.in_ready), 64'(acc));
      if (acc) model_q.push_back('{x: x, y: y});
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic write_random(input int n);
      for (int i = 0; i < n; i++) write_pair(WIDTH'($urandom), WIDTH'($urandom));
      check("count", 64'(bus.count), 64'(model_q.size()));
   endtask

   // mode 0: always ready, 1: fixed stall pattern, 2: random ready
   task automatic beat_loop(input int mode);
      int exp_idx;
      int cyc;
      bit r;
      exp_idx = 0;
      cyc     = 0;
      while (exp_idx < model_q.size() && cyc < 2000) begin
         case (mode)
            0:       r = 1'b1;
            1:       r = pat[cyc % 7];
            default: r = 1'($urandom_range(0, 1));
         endcase
         bus.out_ready = r;
         if (!bus.out_valid) begin
            check("out_valid", 64'(bus.out_valid), 64'd1);
            break;
         end
         check("out_idx", 64'(bus.out_idx), 64'(exp_idx));
         check("out_x", 64'(bus.out_x), 64'(model_q[exp_idx].x));
         check("out_y", 64'(bus.out_y), 64'(model_q[exp_idx].y));
         step();
         if (r) exp_idx++;
         cyc++;
      end
      bus.out_ready = 1'b0;
      check("beats", 64'(exp_idx), 64'(model_q.size()));
      check("dump_done", 64'(bus.dump_done), 64'd1);
      check("out_valid_end", 64'(bus.out_valid), 64'd0);
      model_capture = 1'b0;
   endtask

   task automatic dump(input int mode);
      bus.dump_start = 1'b1;
      step();
      bus.dump_start = 1'b0;
      if (model_q.size() == 0) begin
         check("empty_done", 64'(bus.dump_done), 64'd1);
         for (int i = 0; i < 3; i++) begin
            check("empty_out_valid", 64'(bus.out_valid), 64'd0);
            step();
         end
         model_capture = 1'b0;
      end else begin
         beat_loop(mode);
      end
   endtask

   initial begin
      rst            = 1'b1;
      bus.clear      = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_x       = '0;
      bus.in_y       = '0;
      bus.dump_start = 1'b0;
      bus.out_ready  = 1'b0;
      #12 rst = 1'b0;
      step();

      // Reset state
      check("rst_count", 64'(bus.count), 64'd0);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_x", 64'(bus.out_x), 64'd0);
      check("rst_out_y", 64'(bus.out_y), 64'd0);
      check("rst_out_idx", 64'(bus.out_idx), 64'd0);
      check("rst_dump_done", 64'(bus.dump_done), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_full", 64'(bus.full), 64'd0);

      // Three fixed pairs, y = x + 1
      for (int i = 1; i <= 3; i++) write_pair(WIDTH'(i * 1024), WIDTH'(i * 1024 + 1));
      check("count3", 64'(bus.count), 64'd3);
      dump(0);
      // Writes in DONE are ignored
      write_pair(WIDTH'(5), WIDTH'(6));
      check("done_count", 64'(bus.count), 64'd3);

      // Fill to DEPTH plus one extra attempt
      do_clear();
      write_random(DEPTH + 1);
      check("full", 64'(bus.full), 64'd1);
      check("full_in_ready", 64'(bus.in_ready), 64'd0);
      check("full_count", 64'(bus.count), 64'(DEPTH));
      dump(0);

      // Stalled dump of four pairs
      do_clear();
      write_random(4);
      dump(1);

      // Empty dump, then dump_start together with the first write
      do_clear();
      dump(0);
      do_clear();
      bus.dump_start = 1'b1;
      write_pair(WIDTH'(20'h12345), WIDTH'(20'h6789A));
      bus.dump_start = 1'b0;
      check("same_cycle_count", 64'(bus.count), 64'd1);
      beat_loop(0);

      // clear while idx 2 of 5 is presented
      do_clear();
      write_random(5);
      bus.dump_start = 1'b1;
      step();
      bus.dump_start = 1'b0;
      bus.out_ready  = 1'b1;
      step();
      step();
      check("mid_idx", 64'(bus.out_idx), 64'd2);
      bus.clear = 1'b1;
      step();
      bus.clear     = 1'b0;
      bus.out_ready = 1'b0;
      model_q.delete();
      model_capture = 1'b1;
      check("clr_out_valid", 64'(bus.out_valid), 64'd0);
      check("clr_count", 64'(bus.count), 64'd0);
      check("clr_in_ready", 64'(bus.in_ready), 64'd1);
      check("clr_dump_done", 64'(bus.dump_done), 64'd0);
      check("clr_out_idx", 64'(bus.out_idx), 64'd0);

      // Asynchronous reset in the middle of a dump
      write_random(5);
      bus.dump_start = 1'b1;
      step();
      bus.dump_start = 1'b0;
      bus.out_ready  = 1'b1;
      step();
      #2 rst = 1'b1;
      #1;
      check("arst_out_valid", 64'(bus.out_valid), 64'd0);
      check("arst_count", 64'(bus.count), 64'd0);
      check("arst_out_idx", 64'(bus.out_idx), 64'd0);
      check("arst_out_x", 64'(bus.out_x), 64'd0);
      check("arst_out_y", 64'(bus.out_y), 64'd0);
      #3 rst = 1'b0;
      bus.out_ready = 1'b0;
      model_q.delete();
      model_capture = 1'b1;
      step();

      // Replay from DONE
      write_random(2);
      dump(0);
      dump(0);

      // Randomized rounds
      for (int r = 0; r < 6; r++) begin
         do_clear();
         write_random($urandom_range(0, 12));
         dump(2);
         if (model_q.size() != 0) dump(2);
      end

      $display("CHECKS %0d ERRORS %0d", num_checks, num_errors);
      $finish;
   end

endmodule
